sram_be_clr: RTL and testbench



---
 rtl/sram_be_clr_if.sv | 26 ++
 rtl/sram_be_clr.sv | 163 ++++++++++++++++
 tb/tb_sram_be_clr.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_be_clr_if.sv
// Request/response bundle of the byte-enable SRAM: write port, read port,
// read response and the clear-in-progress flag.
interface sram_be_clr_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 8
);
  logic                  init_busy;
  logic                  we;
  logic [ADDR_W-1:0]     w_addr;
  logic [DATA_W-1:0]     w_data;
  logic [DATA_W/8-1:0]   w_be;
  logic                  re;
  logic [ADDR_W-1:0]     r_addr;
  logic                  r_valid;
  logic [DATA_W-1:0]     r_data;

  modport master (
    input  init_busy, r_valid, r_data,
    output we, w_addr, w_data, w_be, re, r_addr
  );

  modport slave (
    output init_busy, r_valid, r_data,
    input  we, w_addr, w_data, w_be, re, r_addr
  );
endinterface

// File: rtl/sram_be_clr.sv
// Simple dual-port SRAM with byte enables, 1- or 2-cycle read latency,
// selectable read-during-write behaviour and an optional zero clear after reset.
module sram_be_clr #(
  parameter int DATA_W         = 64,
  parameter int DEPTH          = 256,
  parameter int ADDR_W         = $clog2(DEPTH),
  parameter int READ_LAT       = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic          clk,
  input logic          rst,
  sram_be_clr_if.slave bus
);
  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;

  generate
    if ((DATA_W < 8) || ((DATA_W % 8) != 0)) begin : g_bad_data_w
      $error("sram_be_clr: DATA_W must be a positive multiple of 8");
    end
    if (DEPTH < 2) begin : g_bad_depth
      $error("sram_be_clr: DEPTH must be at least 2");
    end
    if ((READ_LAT != 1) && (READ_LAT != 2)) begin : g_bad_lat
      $error("sram_be_clr: READ_LAT must be 1 or 2");
    end
  endgenerate

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
  endfunction

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < BE_W; i++) begin
      res[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return res;
  endfunction

  state_t              state_r;
  logic [ADDR_W-1:0]   clr_cnt_r;
  logic                init_busy_r;
  logic [DATA_W-1:0]   mem_r [DEPTH];
  logic                r_valid_r;
  logic [DATA_W-1:0]   r_data_r;

  logic                wr_ok_s;
  logic                rd_ok_s;
  logic                rdw_hit_s;
  logic [DATA_W-1:0]   old_word_s;
  logic [DATA_W-1:0]   rd_word_s;

  // Qualify requests and pick the word a read returns, including same-edge bypass.
  always_comb begin
    wr_ok_s    = 1'b0;
    rd_ok_s    = 1'b0;
    rdw_hit_s  = 1'b0;
    old_word_s = '0;
    rd_word_s  = '0;
    wr_ok_s    = !rst && (state_r == ST_READY) && bus.we && in_range(bus.w_addr);
    rd_ok_s    = !rst && (state_r == ST_READY) && bus.re;
    if (in_range(bus.r_addr)) begin
      old_word_s = mem_r[bus.r_addr];
    end else begin
      old_word_s = '0;
    end
    rdw_hit_s = (RDW_MODE != 0) && wr_ok_s && (bus.w_addr == bus.r_addr);
    rd_word_s = rdw_hit_s ? merge_bytes(old_word_s, bus.w_data, bus.w_be) : old_word_s;
  end

  // Clear sequencer: INIT walks every address once, then READY until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_READY;
      clr_cnt_r   <= '0;
      init_busy_r <= (CLEAR_ON_RESET != 0);
    end else begin
      case (state_r)
        ST_INIT: begin
          clr_cnt_r <= clr_cnt_r + ADDR_W'(1);
          if (clr_cnt_r == LAST_ADDR) begin
            state_r     <= ST_READY;
            init_busy_r <= 1'b0;
          end
        end
        ST_READY: begin
          state_r     <= ST_READY;
          init_busy_r <= 1'b0;
        end
        default: begin
          state_r     <= ST_INIT;
          clr_cnt_r   <= '0;
          init_busy_r <= 1'b1;
        end
      endcase
    end
  end

  // Array write port: zero fill during INIT, byte-masked writes when READY.
  always_ff @(posedge clk) begin
    if (!rst && (state_r == ST_INIT)) begin
      mem_r[clr_cnt_r] <= '0;
    end else if (wr_ok_s) begin
      for (int i = 0; i < BE_W; i++) begin
        if (bus.w_be[i]) begin
          mem_r[bus.w_addr][8*i +: 8] <= bus.w_data[8*i +: 8];
        end
      end
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic              p_valid_r;
      logic [DATA_W-1:0] p_data_r;

      // Two-stage read pipeline; r_data only moves on a valid beat.
      always_ff @(posedge clk) begin
        if (rst) begin
          p_valid_r <= 1'b0;
          p_data_r  <= '0;
          r_valid_r <= 1'b0;
          r_data_r  <= '0;
        end else begin
          p_valid_r <= rd_ok_s;
          if (rd_ok_s) begin
            p_data_r <= rd_word_s;
          end
          r_valid_r <= p_valid_r;
          if (p_valid_r) begin
            r_data_r <= p_data_r;
          end
        end
      end
    end else begin : g_lat1
      // Single-stage read register; r_data holds between valid beats.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_valid_r <= 1'b0;
          r_data_r  <= '0;
        end else begin
          r_valid_r <= rd_ok_s;
          if (rd_ok_s) begin
            r_data_r <= rd_word_s;
          end
        end
      end
    end
  endgenerate

  assign bus.init_busy = init_busy_r;
  assign bus.r_valid   = r_valid_r;
  assign bus.r_data    = r_data_r;
endmodule

// File: tb/tb_sram_be_clr.sv
// Bench for sram_be_clr: three builds share one stimulus stream and are checked
// against a per-build behavioural model of the memory and read timing.
module tb_sram_be_clr;
  logic        clk;
  logic        rst;
  logic        we;
  logic [3:0]  w_addr;
  logic [31:0] w_data;
  logic [3:0]  w_be;
  logic        re;
  logic [3:0]  r_addr;

  logic        busy_o  [3];
  logic        valid_o [3];
  logic [31:0] data_o  [3];

  // Build 0: lat 1, old-data RDW, clear. Build 1: lat 2, bypass, clear.
  // Build 2: DEPTH 12 (out-of-range addresses exist), lat 2, no clear.
  int dep_c [3] = '{16, 16, 12};
  int lat_c [3] = '{1, 2, 2};
  int rdw_c [3] = '{0, 1, 0};
  int clr_c [3] = '{1, 1, 0};

  sram_be_clr_if #(.DATA_W(32), .ADDR_W(4)) bus0 ();
  sram_be_clr_if #(.DATA_W(32), .ADDR_W(4)) bus1 ();
  sram_be_clr_if #(.DATA_W(32), .ADDR_W(4)) bus2 ();

  sram_be_clr #(.DATA_W(32), .DEPTH(16), .READ_LAT(1), .RDW_MODE(0), .CLEAR_ON_RESET(1))
    u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  sram_be_clr #(.DATA_W(32), .DEPTH(16), .READ_LAT(2), .RDW_MODE(1), .CLEAR_ON_RESET(1))
    u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  sram_be_clr #(.DATA_W(32), .DEPTH(12), .READ_LAT(2), .RDW_MODE(0), .CLEAR_ON_RESET(0))
    u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  assign bus0.we = we; assign bus0.w_addr = w_addr; assign bus0.w_data = w_data;
  assign bus0.w_be = w_be; assign bus0.re = re; assign bus0.r_addr = r_addr;
  assign bus1.we = we; assign bus1.w_addr = w_addr; assign bus1.w_data = w_data;
  assign bus1.w_be = w_be; assign bus1.re = re; assign bus1.r_addr = r_addr;
  assign bus2.we = we; assign bus2.w_addr = w_addr; assign bus2.w_data = w_data;
  assign bus2.w_be = w_be; assign bus2.re = re; assign bus2.r_addr = r_addr;

  assign busy_o[0] = bus0.init_busy; assign valid_o[0] = bus0.r_valid; assign data_o[0] = bus0.r_data;
  assign busy_o[1] = bus1.init_busy; assign valid_o[1] = bus1.r_valid; assign data_o[1] = bus1.r_data;
  assign busy_o[2] = bus2.init_busy; assign valid_o[2] = bus2.r_valid; assign data_o[2] = bus2.r_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: contents with per-byte known flags, clear countdown, and
  // expected responses filed by the cycle they are due.
  int          busy_left [3];
  logic [31:0] mem       [3][16];
  logic [3:0]  mk        [3][16];
  logic        sv        [3][4];
  logic [31:0] sd        [3][4];
  logic [3:0]  sm        [3][4];
  logic        exp_v     [3];
  logic [31:0] last_d    [3];
  logic [31:0] last_w    [3];
  int          cyc;
  int          n_tests;
  int          n_fail;

  function automatic logic [31:0] expand(input logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = {8{m[b]}};
    return r;
  endfunction

  task automatic drive(input logic dwe, input logic [3:0] dwa, input logic [31:0] dwd,
                       input logic [3:0] dbe, input logic dre, input logic [3:0] dra);
    we = dwe; w_addr = dwa; w_data = dwd; w_be = dbe; re = dre; r_addr = dra;
  endtask

  task automatic step();
    logic [31:0] d;
    logic [3:0]  m;
    int          s;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        busy_left[k] = (clr_c[k] != 0) ? dep_c[k] : 0;
        for (int j = 0; j < 4; j++) sv[k][j] = 1'b0;
        last_d[k] = 32'h0;
        last_w[k] = 32'hFFFF_FFFF;
      end else if (busy_left[k] > 0) begin
        mem[k][dep_c[k] - busy_left[k]] = 32'h0;
        mk[k][dep_c[k] - busy_left[k]]  = 4'hF;
        busy_left[k]--;
      end else begin
        if (re) begin
          if (int'(r_addr) < dep_c[k]) begin
            d = mem[k][r_addr]; m = mk[k][r_addr];
          end else begin
            d = 32'h0; m = 4'hF;
          end
          if (rdw_c[k] != 0 && we && w_addr == r_addr && int'(w_addr) < dep_c[k]) begin
            for (int b = 0; b < 4; b++) begin
              if (w_be[b]) begin
                d[8*b +: 8] = w_data[8*b +: 8]; m[b] = 1'b1;
              end
            end
          end
          s = (cyc + lat_c[k]) % 4;
          sv[k][s] = 1'b1; sd[k][s] = d; sm[k][s] = m;
        end
        if (we && int'(w_addr) < dep_c[k]) begin
          for (int b = 0; b < 4; b++) begin
            if (w_be[b]) begin
              mem[k][w_addr][8*b +: 8] = w_data[8*b +: 8];
              mk[k][w_addr][b] = 1'b1;
            end
          end
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 3; k++) begin
      s = cyc % 4;
      exp_v[k] = sv[k][s];
      if (sv[k][s]) begin
        last_d[k] = sd[k][s]; last_w[k] = expand(sm[k][s]);
      end
      sv[k][s] = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0);
    step(); step();
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (busy_o[k] !== (clr_c[k] != 0) || valid_o[k] !== 1'b0 || data_o[k] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset k=%0d busy=%b valid=%b data=%h, want busy=%0d valid=0 data=0",
                 k, busy_o[k], valid_o[k], data_o[k], clr_c[k]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_clear();
    int cnt0;
    int cnt1;
    cnt0 = int'(busy_o[0]);
    cnt1 = int'(busy_o[1]);
    for (int i = 0; i < 40; i++) begin
      if (i < 22) drive(1'($urandom_range(0, 1)), 4'($urandom), $urandom, 4'hF, 1'b1, 4'($urandom));
      else drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'(i - 22));
      step();
      cnt0 += int'(busy_o[0]);
      cnt1 += int'(busy_o[1]);
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (busy_o[k] !== (busy_left[k] > 0) || valid_o[k] !== exp_v[k] ||
            (data_o[k] & last_w[k]) !== (last_d[k] & last_w[k])) begin
          n_fail++;
          $display("FAIL clear k=%0d cyc=%0d busy=%b valid=%b data=%h, want busy=%0d valid=%b data=%h",
                   k, cyc, busy_o[k], valid_o[k], data_o[k], busy_left[k] > 0, exp_v[k], last_d[k]);
        end
      end
    end
    n_tests++;
    if (cnt0 != 16 || cnt1 != 16) begin
      n_fail++;
      $display("FAIL clear_len busy cycles %0d/%0d, want 16/16", cnt0, cnt1);
    end
  endtask

  task automatic test_byte_write();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drive(1'b1, 4'd5, 32'hAABB_CCDD, 4'hF, 1'b0, 4'd0);
        1: drive(1'b1, 4'd5, 32'h1122_3344, 4'b0101, 1'b0, 4'd0);
        2: drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd5);
        default: drive(1'b1, 4'd6, 32'h5555_5555, 4'h0, 1'b0, 4'd0);
      endcase
      step();
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (busy_o[k] !== (busy_left[k] > 0) || valid_o[k] !== exp_v[k] ||
            (data_o[k] & last_w[k]) !== (last_d[k] & last_w[k])) begin
          n_fail++;
          $display("FAIL byte_write k=%0d step=%0d valid=%b data=%h, want valid=%b data=%h",
                   k, i, valid_o[k], data_o[k], exp_v[k], last_d[k]);
        end
      end
      if (i == 2) begin
        n_tests++;
        if (valid_o[0] !== 1'b1 || data_o[0] !== 32'hAA22_CC44) begin
          n_fail++;
          $display("FAIL byte_merge valid=%b data=%h, want 1 aa22cc44", valid_o[0], data_o[0]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 11; i++) begin
      if (i < 4) drive(1'b1, 4'(i), 32'(10 + i), 4'hF, 1'b0, 4'd0);
      else if (i < 8) drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'(i - 4));
      else drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
      step();
      pulses += int'(valid_o[1]);
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (valid_o[k] !== exp_v[k] || (data_o[k] & last_w[k]) !== (last_d[k] & last_w[k])) begin
          n_fail++;
          $display("FAIL back_to_back k=%0d step=%0d valid=%b data=%h, want valid=%b data=%h",
                   k, i, valid_o[k], data_o[k], exp_v[k], last_d[k]);
        end
      end
    end
    n_tests++;
    if (pulses != 4) begin
      n_fail++;
      $display("FAIL b2b_pulses got %0d, want 4", pulses);
    end
  endtask

  task automatic test_rdw();
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: drive(1'b1, 4'd7, 32'h1234_5678, 4'hF, 1'b0, 4'd0);
        1: drive(1'b1, 4'd7, 32'hFFFF_FFFF, 4'b0011, 1'b1, 4'd7);
        3: drive(1'b1, 4'd8, 32'hCAFE_F00D, 4'hF, 1'b1, 4'd7);
        default: drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
      endcase
      step();
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (valid_o[k] !== exp_v[k] || (data_o[k] & last_w[k]) !== (last_d[k] & last_w[k])) begin
          n_fail++;
          $display("FAIL rdw k=%0d step=%0d valid=%b data=%h, want valid=%b data=%h",
                   k, i, valid_o[k], data_o[k], exp_v[k], last_d[k]);
        end
      end
      if (i == 1) begin
        n_tests++;
        if (data_o[0] !== 32'h1234_5678) begin
          n_fail++;
          $display("FAIL rdw_old data=%h, want 12345678", data_o[0]);
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: drive(1'b1, 4'd13, 32'hDEAD_BEEF, 4'hF, 1'b0, 4'd0);
        1: drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd13);
        2: drive(1'b1, 4'd12, 32'h0BAD_CAFE, 4'hF, 1'b1, 4'd12);
        default: drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
      endcase
      step();
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (valid_o[k] !== exp_v[k] || (data_o[k] & last_w[k]) !== (last_d[k] & last_w[k])) begin
          n_fail++;
          $display("FAIL out_of_range k=%0d step=%0d valid=%b data=%h, want valid=%b data=%h",
                   k, i, valid_o[k], data_o[k], exp_v[k], last_d[k]);
        end
      end
    end
  endtask

  task automatic test_rst_midclear();
    int cnt;
    cnt = 0;
    for (int i = 0; i < 28; i++) begin
      rst = (i == 0 || i == 5);
      drive(1'($urandom_range(0, 1)), 4'($urandom), $urandom, 4'($urandom), 1'b1, 4'($urandom));
      step();
      if (i >= 5) cnt += int'(busy_o[0]);
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (busy_o[k] !== (busy_left[k] > 0) || valid_o[k] !== exp_v[k] ||
            (data_o[k] & last_w[k]) !== (last_d[k] & last_w[k])) begin
          n_fail++;
          $display("FAIL rst_midclear k=%0d step=%0d busy=%b valid=%b data=%h, want busy=%0d valid=%b data=%h",
                   k, i, busy_o[k], valid_o[k], data_o[k], busy_left[k] > 0, exp_v[k], last_d[k]);
        end
      end
    end
    rst = 1'b0;
    n_tests++;
    if (cnt != 16) begin
      n_fail++;
      $display("FAIL midclear_len busy cycles %0d, want 16", cnt);
    end
  endtask

  task automatic test_rst_inflight();
    for (int i = 0; i < 6; i++) begin
      rst = (i == 1);
      if (i == 0 || i == 2) drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd5);
      else drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
      step();
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (busy_o[k] !== (busy_left[k] > 0) || valid_o[k] !== exp_v[k] ||
            (data_o[k] & last_w[k]) !== (last_d[k] & last_w[k])) begin
          n_fail++;
          $display("FAIL rst_inflight k=%0d step=%0d valid=%b data=%h, want valid=%b data=%h",
                   k, i, valid_o[k], data_o[k], exp_v[k], last_d[k]);
        end
      end
      if (i == 1 || i == 2) begin
        n_tests++;
        if (valid_o[1] !== 1'b0 || data_o[1] !== 32'h0) begin
          n_fail++;
          $display("FAIL inflight_drop valid=%b data=%h, want 0 00000000", valid_o[1], data_o[1]);
        end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 900; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive(1'($urandom_range(0, 1)), 4'($urandom), $urandom, 4'($urandom),
            1'($urandom_range(0, 1)), 4'($urandom));
      step();
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (busy_o[k] !== (busy_left[k] > 0) || valid_o[k] !== exp_v[k] ||
            (data_o[k] & last_w[k]) !== (last_d[k] & last_w[k])) begin
          n_fail++;
          $display("FAIL random k=%0d cyc=%0d busy=%b valid=%b data=%h, want busy=%0d valid=%b data=%h",
                   k, cyc, busy_o[k], valid_o[k], data_o[k], busy_left[k] > 0, exp_v[k], last_d[k]);
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    for (int k = 0; k < 3; k++) begin
      busy_left[k] = 0;
      exp_v[k]     = 1'b0;
      last_d[k]    = 32'h0;
      last_w[k]    = 32'h0;
      for (int a = 0; a < 16; a++) begin
        mem[k][a] = 32'h0;
        mk[k][a]  = 4'h0;
      end
      for (int j = 0; j < 4; j++) begin
        sv[k][j] = 1'b0; sd[k][j] = 32'h0; sm[k][j] = 4'h0;
      end
    end
    rst = 1'b1;
    drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0);
    @(negedge clk);
    test_reset();
    test_clear();
    test_byte_write();
    test_back_to_back();
    test_rdw();
    test_out_of_range();
    test_rst_midclear();
    test_rst_inflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
